// File: rtl/cavlc_level_coder.sv
// CAVLC level coder: walks one coefficient block from the macroblock BRAM in
// reverse zig-zag order, drops the trailing ones, and streams one complete
// level_prefix/level_suffix code word per remaining nonzero level.
module cavlc_level_coder #(
  parameter int DATA_WIDTH   = 9,
  parameter int ADDR_WIDTH   = 4,
  parameter int MAX_COEFF    = 16,
  parameter int NZQ_WIDTH    = 5,
  parameter int SUFFIX_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_levels,
  input  logic [NZQ_WIDTH-1:0]           blk_len,
  input  logic [NZQ_WIDTH-1:0]           NZQ,
  input  logic [1:0]                     T1s,
  output logic                           mb_bram_en,
  output logic [ADDR_WIDTH-1:0]          mb_bram_address,
  input  logic signed [DATA_WIDTH-1:0]   mb_bram_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     level_prefix,
  output logic [SUFFIX_WIDTH-1:0]        level_suffix,
  output logic [3:0]                     suffix_size,
  output logic                           busy,
  output logic                           finish_levels
);

  localparam int LW = DATA_WIDTH + 1;  // levelCode width
  localparam int CW = 16;              // room for 15<<6 and escape compares

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_EMIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]                   r_state;
  logic [ADDR_WIDTH-1:0]        r_idx;
  logic [NZQ_WIDTH-1:0]         r_nzq;
  logic [NZQ_WIDTH-1:0]         r_seen;
  logic [1:0]                   r_t1s;
  logic                         r_first;
  logic [2:0]                   r_sl;
  logic                         r_end;
  logic signed [DATA_WIDTH-1:0] r_coef;
  logic [3:0]                   r_prefix;
  logic [SUFFIX_WIDTH-1:0]      r_suffix;
  logic [3:0]                   r_size;

  // Block length clamped into 1..MAX_COEFF so the scan never leaves the block
  logic [NZQ_WIDTH-1:0] w_len;
  logic [NZQ_WIDTH-1:0] w_last;
  assign w_len  = (blk_len == '0) ? NZQ_WIDTH'(1) :
                  (blk_len > NZQ_WIDTH'(MAX_COEFF)) ? NZQ_WIDTH'(MAX_COEFF) : blk_len;
  assign w_last = w_len - NZQ_WIDTH'(1);

  // Scan bookkeeping for the coefficient under evaluation
  logic [NZQ_WIDTH-1:0] w_seen_n;
  logic                 w_skip;
  logic                 w_end;
  assign w_seen_n = r_seen + NZQ_WIDTH'(1);
  assign w_skip   = (w_seen_n <= {{(NZQ_WIDTH-2){1'b0}}, r_t1s});
  assign w_end    = (w_seen_n == r_nzq) || (r_idx == '0);

  // levelCode from the latched coefficient
  logic           w_neg;
  logic [LW-1:0]  w_ext;
  logic [LW-1:0]  w_abs;
  logic [LW-1:0]  w_lc;
  logic [CW-1:0]  w_lcx;
  logic [CW-1:0]  w_lim;

  // Magnitude and levelCode, including the first-level bias when T1s<3
  always_comb begin
    w_neg = r_coef[DATA_WIDTH-1];
    w_ext = {r_coef[DATA_WIDTH-1], r_coef};
    w_abs = w_neg ? (~w_ext + LW'(1)) : w_ext;
    w_lc  = w_neg ? ({w_abs[LW-2:0], 1'b0} - LW'(1)) : ({w_abs[LW-2:0], 1'b0} - LW'(2));
    if (r_first && (r_t1s != 2'd3)) w_lc = w_lc - LW'(2);
    w_lcx = CW'(w_lc);
    w_lim = CW'(15) << r_sl;
  end

  logic [3:0]              w_pre;
  logic [SUFFIX_WIDTH-1:0] w_suf;
  logic [3:0]              w_size;

  // Prefix/suffix split for the current suffixLength, escape at prefix 15
  always_comb begin
    w_pre  = '0;
    w_suf  = '0;
    w_size = '0;
    if (r_sl == 3'd0) begin
      if (w_lcx < CW'(14)) begin
        w_pre = w_lcx[3:0];
      end else if (w_lcx < CW'(30)) begin
        w_pre  = 4'd14;
        w_suf  = SUFFIX_WIDTH'(w_lcx - CW'(14));
        w_size = 4'd4;
      end else begin
        w_pre  = 4'd15;
        w_suf  = SUFFIX_WIDTH'(w_lcx - CW'(30));
        w_size = 4'd12;
      end
    end else if (w_lcx < w_lim) begin
      w_pre  = 4'(w_lcx >> r_sl);
      w_suf  = SUFFIX_WIDTH'(w_lcx & ~({CW{1'b1}} << r_sl));
      w_size = {1'b0, r_sl};
    end else begin
      w_pre  = 4'd15;
      w_suf  = SUFFIX_WIDTH'(w_lcx - w_lim);
      w_size = 4'd12;
    end
  end

  logic [2:0]    w_sl1;
  logic [CW-1:0] w_thr;
  logic [2:0]    w_sl_next;

  // suffixLength adaptation applied once the code word is accepted
  always_comb begin
    w_sl1     = (r_sl == 3'd0) ? 3'd1 : r_sl;
    w_thr     = CW'(3) << (w_sl1 - 3'd1);
    w_sl_next = ((CW'(w_abs) > w_thr) && (w_sl1 < 3'd6)) ? (w_sl1 + 3'd1) : w_sl1;
  end

  // Scan FSM and code-word registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_nzq    <= '0;
      r_seen   <= '0;
      r_t1s    <= '0;
      r_first  <= 1'b0;
      r_sl     <= '0;
      r_end    <= 1'b0;
      r_coef   <= '0;
      r_prefix <= '0;
      r_suffix <= '0;
      r_size   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_levels) begin
            r_idx   <= w_last[ADDR_WIDTH-1:0];
            r_nzq   <= NZQ;
            r_t1s   <= T1s;
            r_seen  <= '0;
            r_first <= 1'b1;
            r_sl    <= ((NZQ > NZQ_WIDTH'(10)) && (T1s != 2'd3)) ? 3'd1 : 3'd0;
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_coef  <= mb_bram_data;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          if (r_coef == '0) begin
            if (r_idx == '0) r_state <= S_DONE;
            else begin
              r_idx   <= r_idx - ADDR_WIDTH'(1);
              r_state <= S_READ;
            end
          end else begin
            r_seen <= w_seen_n;
            if (w_skip) begin
              if (w_end) r_state <= S_DONE;
              else begin
                r_idx   <= r_idx - ADDR_WIDTH'(1);
                r_state <= S_READ;
              end
            end else begin
              r_prefix <= w_pre;
              r_suffix <= w_suf;
              r_size   <= w_size;
              r_end    <= w_end;
              r_state  <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_sl     <= w_sl_next;
            r_first  <= 1'b0;
            r_prefix <= '0;
            r_suffix <= '0;
            r_size   <= '0;
            if (r_end) r_state <= S_DONE;
            else begin
              r_idx   <= r_idx - ADDR_WIDTH'(1);
              r_state <= S_READ;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mb_bram_en      = (r_state == S_READ);
  assign mb_bram_address = (r_state == S_READ) ? r_idx : '0;
  assign out_valid       = (r_state == S_EMIT);
  assign level_prefix    = r_prefix;
  assign level_suffix    = r_suffix;
  assign suffix_size     = r_size;
  assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);
  assign finish_levels   = (r_state == S_DONE);

endmodule

// File: tb/tb_cavlc_level_coder.sv
// Bench for cavlc_level_coder: directed spec cases, backpressure, reset
// mid-emit, ignored restart, then randomized blocks against a reference model.
module tb_cavlc_level_coder;
  localparam int DW = 9;
  localparam int AW = 4;
  localparam int NW = 5;
  localparam int SW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_levels = 1'b0;
  logic out_ready = 1'b0;
  logic [NW-1:0] blk_len = '0;
  logic [NW-1:0] NZQ = '0;
  logic [1:0]    T1s = '0;
  logic          mb_bram_en;
  logic [AW-1:0] mb_bram_address;
  logic signed [DW-1:0] mb_bram_data;
  logic          out_valid;
  logic [3:0]    level_prefix;
  logic [SW-1:0] level_suffix;
  logic [3:0]    suffix_size;
  logic          busy;
  logic          finish_levels;

  int tests = 0;
  int fails = 0;

  logic signed [DW-1:0] mem [16];
  logic [19:0] exp_q[$];
  logic [19:0] emit_q[$];
  int          exp_rd[$];
  int          rd_q[$];
  int          fin_cnt;
  logic        hold = 1'b0;
  logic [19:0] held;

  always #5 clk = ~clk;

  cavlc_level_coder dut (
    .clk(clk), .rst(rst), .start_levels(start_levels),
    .blk_len(blk_len), .NZQ(NZQ), .T1s(T1s),
    .mb_bram_en(mb_bram_en), .mb_bram_address(mb_bram_address),
    .mb_bram_data(mb_bram_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .level_prefix(level_prefix), .level_suffix(level_suffix),
    .suffix_size(suffix_size), .busy(busy), .finish_levels(finish_levels)
  );

  // registered-read BRAM
  always @(posedge clk) if (mb_bram_en) mb_bram_data <= mem[mb_bram_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One code word straight from the levelCode / suffixLength rules
  function automatic logic [19:0] code_of(input int v, input int sl, input bit first, input int t1);
    int a, lc, lim, p, s, z;
    a  = (v < 0) ? -v : v;
    lc = (v > 0) ? 2*a - 2 : 2*a - 1;
    if (first && t1 < 3) lc -= 2;
    if (sl == 0) begin
      if (lc < 14)      begin p = lc; s = 0;       z = 0;  end
      else if (lc < 30) begin p = 14; s = lc - 14; z = 4;  end
      else              begin p = 15; s = lc - 30; z = 12; end
    end else begin
      lim = 15 * (1 << sl);
      if (lc < lim) begin p = lc / (1 << sl); s = lc % (1 << sl); z = sl; end
      else          begin p = 15; s = lc - lim; z = 12; end
    end
    return {p[3:0], s[11:0], z[3:0]};
  endfunction

  // Expected read addresses and code words for the current mem contents
  function automatic void model(input int bl, input int nzq, input int t1);
    int sl, seen, v, a;
    bit first;
    exp_q.delete();
    exp_rd.delete();
    sl = (nzq > 10 && t1 < 3) ? 1 : 0;
    first = 1'b1;
    seen = 0;
    for (int i = bl - 1; i >= 0; i--) begin
      exp_rd.push_back(i);
      v = int'(mem[i]);
      if (v != 0) begin
        seen++;
        if (seen > t1) begin
          exp_q.push_back(code_of(v, sl, first, t1));
          a = (v < 0) ? -v : v;
          if (sl == 0) sl = 1;
          if (a > 3 * (1 << (sl - 1)) && sl < 6) sl++;
          first = 1'b0;
        end
        if (seen == nzq) break;
      end
    end
  endfunction

  function automatic int rnd_val(input int lo, input int hi);
    int v;
    v = int'($urandom_range(hi, lo));
    if ($urandom_range(1, 0) == 1) v = -v;
    return v;
  endfunction

  // Output monitor: records reads/emits, checks stability under backpressure
  always @(negedge clk) begin
    if (!rst) hold = 1'b0;
    else begin
      if (mb_bram_en) rd_q.push_back(int'(mb_bram_address));
      if (out_valid) chk("no_read_in_emit", 32'(mb_bram_en), 32'(0));
      if (hold) begin
        chk("bp_valid_held", 32'(out_valid), 32'(1));
        chk("bp_fields_held", 32'({level_prefix, level_suffix, suffix_size}), 32'(held));
      end
      if (out_valid && out_ready) emit_q.push_back({level_prefix, level_suffix, suffix_size});
      if (finish_levels) begin
        fin_cnt++;
        chk("busy_low_at_finish", 32'(busy), 32'(0));
      end
      hold = out_valid && !out_ready;
      held = {level_prefix, level_suffix, suffix_size};
    end
  end

  // mode 0: ready high, 1: random ready, 2: ready low 3 cycles per emit
  task automatic run_block(input int bl, input int nzq, input int t1, input int mode,
                           input bit poke, input string tag);
    int cyc, lowcnt;
    model(bl, nzq, t1);
    emit_q.delete();
    rd_q.delete();
    fin_cnt = 0;
    @(posedge clk); #1;
    blk_len = NW'(bl);
    NZQ = NW'(nzq);
    T1s = 2'(t1);
    start_levels = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    lowcnt = 0;
    do begin
      @(posedge clk); #1;
      start_levels = poke && (cyc == 3);
      if (poke && cyc == 3) begin blk_len = NW'(4); NZQ = NW'(1); T1s = 2'd0; end
      case (mode)
        1: out_ready = ($urandom_range(1, 0) == 1);
        2: begin
          if (out_valid && lowcnt < 3) begin out_ready = 1'b0; lowcnt++; end
          else begin out_ready = 1'b1; if (!out_valid) lowcnt = 0; end
        end
        default: out_ready = 1'b1;
      endcase
      cyc++;
    end while (!finish_levels && cyc < 3000);
    chk({tag, "_finish_seen"}, 32'(finish_levels), 32'(1));
    start_levels = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
    chk({tag, "_finish_count"}, 32'(fin_cnt), 32'(1));
    chk({tag, "_emit_count"}, 32'(emit_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_emit"}, 32'(emit_q[i]), 32'(exp_q[i]));
    chk({tag, "_read_count"}, 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size(); i++)
      chk({tag, "_read_addr"}, 32'(rd_q[i]), 32'(exp_rd[i]));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  initial begin
    int bl, k, t1, c, v, mode, cyc;
    bit poke;
    bit nzmask [16];

    // reset state
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 32'(mb_bram_en), 32'(0));
    chk("rst_addr", 32'(mb_bram_address), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_fields", 32'({level_prefix, level_suffix, suffix_size}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_finish", 32'(finish_levels), 32'(0));
    rst = 1'b1;

    // two emits after skipping three trailing ones
    clear_mem();
    mem[1] = 9'sd3; mem[2] = -9'sd1; mem[5] = -9'sd1; mem[6] = 9'sd1; mem[8] = 9'sd1;
    run_block(16, 5, 3, 0, 1'b0, "t1s3");
    chk("t1s3_w0", 32'(emit_q[0]), 32'({4'd1, 12'd0, 4'd0}));
    chk("t1s3_w1", 32'(emit_q[1]), 32'({4'd2, 12'd0, 4'd1}));
    chk("t1s3_last_addr", 32'(rd_q[rd_q.size()-1]), 32'(1));

    // first-level bias with T1s<3
    clear_mem();
    mem[0] = 9'sd5; mem[1] = -9'sd2; mem[2] = 9'sd1;
    run_block(16, 3, 1, 0, 1'b0, "bias");
    chk("bias_w0", 32'(emit_q[0]), 32'({4'd1, 12'd0, 4'd0}));
    chk("bias_w1", 32'(emit_q[1]), 32'({4'd4, 12'd0, 4'd1}));

    // sL=0 escape
    clear_mem();
    mem[0] = 9'sd20;
    run_block(16, 1, 0, 0, 1'b0, "esc0");
    chk("esc0_w0", 32'(emit_q[0]), 32'({4'd15, 12'd6, 4'd12}));

    // NZQ>10 starts at sL=1
    clear_mem();
    mem[15] = -9'sd4;
    for (int i = 5; i < 15; i++) mem[i] = DW'(rnd_val(1, 3));
    run_block(16, 11, 0, 1, 1'b0, "sl1");
    chk("sl1_w0", 32'(emit_q[0]), 32'({4'd2, 12'd1, 4'd1}));

    // backpressure, and a start pulse while busy
    clear_mem();
    mem[0] = 9'sd5; mem[1] = -9'sd2; mem[2] = 9'sd1;
    run_block(16, 3, 1, 2, 1'b0, "bp");
    clear_mem();
    mem[1] = 9'sd3; mem[2] = -9'sd1; mem[5] = -9'sd1; mem[6] = 9'sd1; mem[8] = 9'sd1;
    run_block(16, 5, 3, 2, 1'b1, "restart_ignored");

    // all nonzeros are trailing ones
    clear_mem();
    mem[10] = 9'sd1; mem[5] = -9'sd1; mem[3] = 9'sd1;
    run_block(15, 3, 3, 0, 1'b0, "noemit");
    chk("noemit_count", 32'(emit_q.size()), 32'(0));

    // reset in the middle of an emit
    clear_mem();
    mem[0] = 9'sd20;
    emit_q.delete();
    @(posedge clk); #1;
    blk_len = NW'(4); NZQ = NW'(1); T1s = 2'd0; start_levels = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start_levels = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("rstmid_emit_reached", 32'(out_valid), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'(0));
    chk("rstmid_fields", 32'({level_prefix, level_suffix, suffix_size}), 32'(0));
    chk("rstmid_busy", 32'(busy), 32'(0));
    chk("rstmid_en", 32'(mb_bram_en), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_post_valid", 32'(out_valid), 32'(0));
    chk("rstmid_post_busy", 32'(busy), 32'(0));
    chk("rstmid_post_emits", 32'(emit_q.size()), 32'(0));

    // randomized blocks
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(2, 0))
        0: bl = 4;
        1: bl = 15;
        default: bl = 16;
      endcase
      k = 0;
      for (int i = 0; i < 16; i++) begin
        nzmask[i] = (i < bl) && ($urandom_range(2, 0) == 0);
        if (nzmask[i]) k++;
      end
      if (k == 0) begin nzmask[$urandom_range(bl - 1, 0)] = 1'b1; k = 1; end
      t1 = int'($urandom_range((k < 3) ? k : 3, 0));
      c = 0;
      for (int i = 15; i >= 0; i--) begin
        if (i >= bl) mem[i] = DW'(rnd_val(1, 255));
        else if (!nzmask[i]) mem[i] = '0;
        else begin
          if (c < t1) v = rnd_val(1, 1);
          else if (c == t1 && t1 < 3) v = ($urandom_range(3, 0) == 0) ? rnd_val(2, 255) : rnd_val(2, 12);
          else v = ($urandom_range(3, 0) == 0) ? rnd_val(1, 255) : rnd_val(1, 12);
          if ($urandom_range(15, 0) == 0) v = -256;
          mem[i] = DW'(v);
          c++;
        end
      end
      mode = int'($urandom_range(2, 0));
      poke = ($urandom_range(3, 0) == 0);
      run_block(bl, k, t1, mode, poke, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
